rc4_keystream: RTL and testbench
================================

// Module: rc4_keystream
// PURPOSE
//   RC4 keystream generator. Feeds the decrypt stage: K is XORed with ciphertext there; ks_req is that stage's data-valid strobe.
//   Accepts a byte-serial password, runs S-box init (256 cy) + KSA (256 cy), then emits one keystream byte per request.
//   S-box is a 256x8 register array; one KSA/PRGA step per clock.
// PARAMETERS
//   KEY_MAX  16   max password bytes stored (1..256); extra bytes dropped
//   DROP_N   256  keystream bytes discarded after KSA (only with RC4_DROP_EN)
// PORTS
//   clk        in   1  system clock, all logic on posedge
//   rst        in   1  synchronous, active-high reset
//   password   in   8  password byte
//   key_valid  in   1  password byte valid this cycle
//   key_last   in   1  qualifies final password byte (with key_valid)
//   ks_req     in   1  request next keystream byte
//   K          out  8  keystream byte
//   k_valid    out  1  K valid (1-cycle pulse per request)
//   init_done  out  1  KSA complete, ready for ks_req
//   key_ovf    out  1  sticky: password exceeded KEY_MAX bytes
// BEHAVIOUR
// - Reset: state=LOAD, K=0, k_valid=0, init_done=0, key_ovf=0, len=0, i=j=0; S contents undefined until INIT.
// - States: LOAD -> INIT -> KSA -> [DROP] -> READY.
// - LOAD: each key_valid writes key[len]; len++ (saturates at KEY_MAX, further bytes dropped, key_ovf=1).
//   key_valid&key_last -> INIT next cycle. key_last on first byte => length 1. key_last w/o key_valid ignored.
// - INIT: n=0..255, S[n]=n, 256 cycles.
// - KSA: 256 cycles; i=0..255: j=j+S[i]+key[kidx]; swap S[i],S[j]; kidx wraps at len (counter compare, no divide).
//   On exit, i=j=0.
// - Timing: key_last accepted cycle t -> INIT t+1..t+256, KSA t+257..t+512, init_done=1 at t+513 (no drop).
// - READY: ks_req=1 in cycle c -> i=i+1; j=j+S[i]; swap; K=S'[(S[i]+S[j]) mod 256] using POST-swap array S'.
//   k_valid=1 and K updated in cycle c+1. Back-to-back reqs give 1 byte/cycle. K holds its last value when k_valid=0.
// - All index/sum arithmetic 8-bit, wraps modulo 256 (i=255 -> 0).
// - ks_req while init_done=0: ignored, no k_valid, no state change.
// - key_valid outside LOAD/READY: ignored.
// - Rekey: key_valid in READY -> init_done=0 next cycle; byte stored as key[0]; len=1 (or INIT if key_last);
//   key_ovf cleared; ks_req in same cycle is dropped (rekey wins).
// - rst mid-operation (any state): next cycle equals reset state; in-flight k_valid suppressed.
// CONFIGURATION
//   RC4_DROP_EN defined: DROP state after KSA runs DROP_N PRGA steps internally (k_valid stays 0);
//     init_done rises DROP_N cycles later (t+513+DROP_N). RC4-dropN.
//   RC4_DROP_EN undefined: KSA -> READY directly; DROP_N unused; first K after init_done is keystream byte 0.
// TESTING
// 1. password "Key" (4B 65 79, key_last on 79), 10 reqs -> K = EB 9F 77 81 B7 34 CA 72 A7 19; init_done at t+513.
// 2. password "Wiki" (57 69 6B 69), 6 reqs -> K = 60 44 DB 6D 41 B7; back-to-back, k_valid high 6 consecutive cycles.
// 3. ks_req pulsed during KSA, then "Key" -> no k_valid before init_done; first byte EB.
// 4. 3 reqs after "Key" (EB 9F 77), then rekey "Wiki" with ks_req same cycle
//    -> no k_valid that cycle, init_done drops, next bytes 60 44...
// 5. KEY_MAX=4, 6 password bytes "Wiki!!" -> key_ovf=1, keystream equals "Wiki" vector 60 44 DB.
// 6. rst asserted mid-KSA, then "Key" -> outputs at reset values next cycle; keystream EB 9F 77.
//    With RC4_DROP_EN, DROP_N=1: "Key" -> first K=9F, init_done at t+514.

Source files
------------

// File: rtl/rc4_keystream.sv
// RC4 keystream generator: byte-serial key load, S-box init + KSA, then one PRGA byte per request.
// Optional macro RC4_DROP_EN discards the first DROP_N keystream bytes before raising init_done.
module rc4_keystream #(
  parameter int KEY_MAX = 16,
  parameter int DROP_N  = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] password,
  input  logic       key_valid,
  input  logic       key_last,
  input  logic       ks_req,
  output logic [7:0] K,
  output logic       k_valid,
  output logic       init_done,
  output logic       key_ovf
);

  localparam int         KIDX_W    = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam int         KEY_SLOTS = 1 << KIDX_W;
  localparam logic [8:0] KEY_MAX_L = 9'(KEY_MAX);

  typedef enum logic [2:0] {ST_LOAD, ST_INIT, ST_KSA, ST_DROP, ST_READY} state_t;

  state_t     state, state_nx;
  logic [7:0] s_box   [256];
  logic [7:0] key_mem [KEY_SLOTS];
  logic [7:0] i, j;
  logic [8:0] len, kidx, kidx_nx;
  logic       i_last, req_ok, prga_step, drop_last;

  // A swap writes S[i] and S[j]; the output byte must see the array after that swap.
  function automatic logic [7:0] post_swap_rd(input logic [7:0] t, input logic [7:0] ia,
                                              input logic [7:0] ja, input logic [7:0] si,
                                              input logic [7:0] sj, input logic [7:0] st);
    if (t == ia)      return sj;
    else if (t == ja) return si;
    else              return st;
  endfunction

  logic [7:0] ksa_si, ksa_j, ksa_sj;
  assign ksa_si  = s_box[i];
  assign ksa_j   = j + ksa_si + key_mem[kidx[KIDX_W-1:0]];
  assign ksa_sj  = s_box[ksa_j];
  assign kidx_nx = (kidx + 9'd1 == len) ? 9'd0 : kidx + 9'd1;

  logic [7:0] prga_i, prga_si, prga_j, prga_sj, prga_t, prga_k;
  assign prga_i  = i + 8'd1;
  assign prga_si = s_box[prga_i];
  assign prga_j  = j + prga_si;
  assign prga_sj = s_box[prga_j];
  assign prga_t  = prga_si + prga_sj;
  assign prga_k  = post_swap_rd(prga_t, prga_i, prga_j, prga_si, prga_sj, s_box[prga_t]);

  assign i_last    = (i == 8'hFF);
  assign req_ok    = (state == ST_READY) && ks_req && !key_valid;
  assign prga_step = req_ok || (state == ST_DROP);
  assign init_done = (state == ST_READY);

`ifdef RC4_DROP_EN
  localparam int DROP_W = (DROP_N > 1) ? $clog2(DROP_N) : 1;
  logic [DROP_W-1:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (rst)                    drop_cnt <= '0;
    else if (state == ST_DROP)  drop_cnt <= drop_cnt + 1'b1;
    else                        drop_cnt <= '0;
  end

  assign drop_last = (drop_cnt == DROP_W'(DROP_N - 1));
`else
  logic unused_drop_n;
  assign unused_drop_n = (DROP_N != 0);
  assign drop_last     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:  if (key_valid && key_last) state_nx = ST_INIT;
      ST_INIT:  if (i_last) state_nx = ST_KSA;
      ST_KSA: begin
        if (i_last) begin
`ifdef RC4_DROP_EN
          state_nx = (DROP_N > 0) ? ST_DROP : ST_READY;
`else
          state_nx = ST_READY;
`endif
        end
      end
      ST_DROP:  if (drop_last) state_nx = ST_READY;
      ST_READY: if (key_valid) state_nx = key_last ? ST_INIT : ST_LOAD;
      default:  state_nx = ST_LOAD;
    endcase
  end

  // Key and S-box storage carry no reset; INIT rewrites S before any use.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && key_valid && len < KEY_MAX_L)
      key_mem[len[KIDX_W-1:0]] <= password;
    else if (state == ST_READY && key_valid)
      key_mem[0] <= password;

    case (state)
      ST_INIT: s_box[i] <= i;
      ST_KSA: begin
        s_box[i]     <= ksa_sj;
        s_box[ksa_j] <= ksa_si;
      end
      default: begin
        if (prga_step) begin
          s_box[prga_i] <= prga_sj;
          s_box[prga_j] <= prga_si;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i       <= 8'd0;
      j       <= 8'd0;
      len     <= 9'd0;
      kidx    <= 9'd0;
      key_ovf <= 1'b0;
      k_valid <= 1'b0;
      K       <= 8'd0;
    end else begin
      k_valid <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (key_valid) begin
            if (len < KEY_MAX_L) len <= len + 9'd1;
            else                 key_ovf <= 1'b1;
          end
        end
        ST_INIT: i <= i + 8'd1;
        ST_KSA: begin
          i <= i + 8'd1;
          if (i_last) begin
            j    <= 8'd0;
            kidx <= 9'd0;
          end else begin
            j    <= ksa_j;
            kidx <= kidx_nx;
          end
        end
        ST_DROP: begin
          i <= prga_i;
          j <= prga_j;
        end
        ST_READY: begin
          // A new key byte takes priority over a same-cycle keystream request.
          if (key_valid) begin
            i       <= 8'd0;
            j       <= 8'd0;
            kidx    <= 9'd0;
            len     <= 9'd1;
            key_ovf <= 1'b0;
          end else if (ks_req) begin
            i       <= prga_i;
            j       <= prga_j;
            K       <= prga_k;
            k_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_keystream.sv
// Directed bench for rc4_keystream: known RC4 vectors, request gating, rekey and reset mid-operation.
module tb_rc4_keystream;

`ifdef RC4_DROP_EN
  localparam int DOFF = 1;
`else
  localparam int DOFF = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, key_valid, key_last, ks_req;
  logic [7:0] password;
  logic [7:0] K;
  logic       k_valid, init_done, key_ovf;

  always #5 clk = ~clk;

  rc4_keystream #(.KEY_MAX(16), .DROP_N(1)) dut (
    .clk(clk), .rst(rst), .password(password), .key_valid(key_valid), .key_last(key_last),
    .ks_req(ks_req), .K(K), .k_valid(k_valid), .init_done(init_done), .key_ovf(key_ovf)
  );

  typedef struct {
    logic [0:19][7:0] key;
    int               len;
    int               nreq;
    logic [0:9][7:0]  exp;
    logic             ovf;
  } vec_t;

  vec_t vecs[3];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; key_valid = 1'b0; key_last = 1'b0; ks_req = 1'b0; password = 8'h00;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic send_key(input vec_t v, input int start);
    for (int b = start; b < v.len; b++) begin
      password  = v.key[b];
      key_valid = 1'b1;
      key_last  = (b == v.len - 1);
      tick;
    end
    key_valid = 1'b0; key_last = 1'b0; password = 8'h00;
  endtask

  // Called in the cycle after key_last; init_done is due 512 (+drop) ticks later.
  task automatic wait_ready(input string name, input int pulse);
    int   n = 0;
    logic saw = 1'b0;
    while (init_done !== 1'b1 && n < 2000) begin
      ks_req = (pulse != 0) && ((n % pulse) == 3);
      tick;
      n++;
      if (k_valid === 1'b1 && init_done !== 1'b1) saw = 1'b1;
    end
    ks_req = 1'b0;
    chk($sformatf("%s init_done latency", name), n, 512 + DOFF);
    if (pulse != 0) chk($sformatf("%s k_valid before ready", name), 32'(saw), 0);
  endtask

  task automatic run_stream(input string name, input logic [0:9][7:0] exp, input int nreq);
    for (int k = 0; k < nreq - DOFF; k++) begin
      ks_req = 1'b1;
      tick;
      chk($sformatf("%s k_valid[%0d]", name, k), 32'(k_valid), 1);
      chk($sformatf("%s K[%0d]", name, k), 32'(K), 32'(exp[k + DOFF]));
    end
    ks_req = 1'b0;
    tick;
    chk($sformatf("%s k_valid idle", name), 32'(k_valid), 0);
    chk($sformatf("%s K hold", name), 32'(K), 32'(exp[nreq - 1]));
  endtask

  task automatic rekey_first(input string name, input logic [7:0] b0);
    password = b0; key_valid = 1'b1; key_last = 1'b0; ks_req = 1'b1;
    tick;
    key_valid = 1'b0; ks_req = 1'b0; password = 8'h00;
    chk($sformatf("%s k_valid on rekey", name), 32'(k_valid), 0);
    chk($sformatf("%s init_done on rekey", name), 32'(init_done), 0);
    chk($sformatf("%s key_ovf on rekey", name), 32'(key_ovf), 0);
  endtask

  initial begin
    vecs[0].key = {8'h4B, 8'h65, 8'h79, 136'h0};
    vecs[0].len = 3;  vecs[0].nreq = 10; vecs[0].ovf = 1'b0;
    vecs[0].exp = {8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    vecs[1].key = {8'h57, 8'h69, 8'h6B, 8'h69, 128'h0};
    vecs[1].len = 4;  vecs[1].nreq = 6;  vecs[1].ovf = 1'b0;
    vecs[1].exp = {8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7, 32'h0};
    vecs[2].key = {{4{32'h57696B69}}, 16'h2121, 16'h0};
    vecs[2].len = 18; vecs[2].nreq = 3;  vecs[2].ovf = 1'b1;
    vecs[2].exp = {8'h60, 8'h44, 8'hDB, 56'h0};

    do_reset;
    chk("reset K", 32'(K), 0);
    chk("reset k_valid", 32'(k_valid), 0);
    chk("reset init_done", 32'(init_done), 0);
    chk("reset key_ovf", 32'(key_ovf), 0);

    // Requests and a lone key_last in LOAD must do nothing; requests during INIT/KSA are ignored.
    ks_req = 1'b1; tick; ks_req = 1'b0;
    chk("req in LOAD", 32'(k_valid), 0);
    key_last = 1'b1; tick; key_last = 1'b0;
    send_key(vecs[0], 0);
    wait_ready("pulsed", 37);
    run_stream("pulsed", vecs[0].exp, 3);

    for (int v = 0; v < 3; v++) begin
      do_reset;
      send_key(vecs[v], 0);
      wait_ready($sformatf("vec%0d", v), 0);
      chk($sformatf("vec%0d key_ovf", v), 32'(key_ovf), 32'(vecs[v].ovf));
      run_stream($sformatf("vec%0d", v), vecs[v].exp, vecs[v].nreq);
    end

    // Rekey from READY (key_ovf still set from the overflow vector).
    rekey_first("rekey Key", 8'h4B);
    send_key(vecs[0], 1);
    wait_ready("rekey Key", 0);
    run_stream("rekey Key", vecs[0].exp, 3);
    rekey_first("rekey Wiki", 8'h57);
    send_key(vecs[1], 1);
    wait_ready("rekey Wiki", 0);
    run_stream("rekey Wiki", vecs[1].exp, 3);

    // Reset while a request is in flight, then reset in the middle of KSA.
    ks_req = 1'b1; rst = 1'b1;
    tick;
    ks_req = 1'b0; rst = 1'b0;
    chk("rst READY k_valid", 32'(k_valid), 0);
    chk("rst READY K", 32'(K), 0);
    chk("rst READY init_done", 32'(init_done), 0);
    send_key(vecs[0], 0);
    repeat (300) tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk("rst KSA init_done", 32'(init_done), 0);
    chk("rst KSA k_valid", 32'(k_valid), 0);
    repeat (600) tick;
    chk("rst KSA stays idle", 32'(init_done), 0);
    send_key(vecs[0], 0);
    wait_ready("after rst", 0);
    run_stream("after rst", vecs[0].exp, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
